// File: rtl/cam_soc_nios2_qsys_0_cpu_debug_ocimem_ctrl_if.sv
// Avalon-MM bus between the CPU monitor code and the OCI debug memory.
// The master side is the CPU, the slave side is the debug memory controller.
interface cam_soc_nios2_qsys_0_cpu_debug_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W:0] avs_address;
  logic            avs_read;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic [31:0]     avs_readdata;
  logic            avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/cam_soc_nios2_qsys_0_cpu_debug_ocimem_ctrl.sv
// JTAG-side OCI debug memory controller.
// Debug commands (take_* pulses with jdo payload) and the CPU Avalon port share
// one single-ported debug RAM and the monitor control register. Debug commands
// always win: while the command FSM is busy, or a command pulse is present, CPU
// RAM accesses are stalled with waitrequest and simply retried by the master.
module cam_soc_nios2_qsys_0_cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [37:0]                               jdo,
  input  logic                                      take_action_ocimem_a,
  input  logic                                      take_no_action_ocimem_a,
  input  logic                                      take_action_ocimem_b,
  cam_soc_nios2_qsys_0_cpu_debug_ocimem_ctrl_if.slave avs,
  output logic [31:0]                               MonDReg,
  output logic [ADDR_W-1:0]                         MonAReg,
  output logic                                      monitor_ready,
  output logic                                      monitor_error,
  output logic                                      monitor_go,
  output logic                                      cmd_overrun
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ADDR = 2'd1,
    ST_RD_CAP  = 2'd2,
    ST_WR      = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  logic [31:0]        mem_r [DEPTH];
  logic [31:0]        ram_q_r;
  logic [31:0]        wdata_r;
  logic               rd_inc_r;
  logic               rd_phase_r;

  logic               idle_s;
  logic               any_take_s;
  logic               multi_take_s;
  logic               a_acc_s;
  logic               b_acc_s;
  logic               n_acc_s;
  logic               go_acc_s;
  logic               drop_s;
  logic               blocked_s;
  logic               ctrl_sel_s;
  logic               ram_rd_s;
  logic               ram_wr_s;
  logic               ctrl_wr_s;
  logic               ram_we_s;
  logic [ADDR_W-1:0]  ram_addr_s;
  logic [31:0]        ram_wdata_s;
  logic [ADDR_W-1:0]  jdo_addr_s;
  logic [1:0]         take_cnt_s;
  logic               waitrequest_s;
  logic [31:0]        readdata_s;
  logic               unused_jdo_s;

  assign jdo_addr_s   = jdo[17 +: ADDR_W];
  assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

  // Command arbitration, CPU decode and shared-RAM port steering.
  always_comb begin
    idle_s       = (state_r == ST_IDLE);
    take_cnt_s   = {1'b0, take_action_ocimem_a} + {1'b0, take_action_ocimem_b}
                 + {1'b0, take_no_action_ocimem_a};
    any_take_s   = (take_cnt_s != 2'd0);
    multi_take_s = (take_cnt_s > 2'd1);
    a_acc_s      = idle_s && take_action_ocimem_a;
    b_acc_s      = idle_s && take_action_ocimem_b && !take_action_ocimem_a;
    n_acc_s      = idle_s && take_no_action_ocimem_a && !take_action_ocimem_a
                 && !take_action_ocimem_b;
    go_acc_s     = a_acc_s && jdo[35];
    drop_s       = (!idle_s && any_take_s) || (idle_s && multi_take_s);
    blocked_s    = !idle_s || any_take_s;
    ctrl_sel_s   = avs.avs_address[ADDR_W];
    ram_rd_s     = avs.avs_read && !ctrl_sel_s;
    ram_wr_s     = avs.avs_write && !ctrl_sel_s;
    ctrl_wr_s    = avs.avs_write && ctrl_sel_s;
    // The CPU owns the RAM port only while the debug FSM is idle.
    ram_we_s     = reset_n && ((state_r == ST_WR) || (ram_wr_s && !blocked_s));
    if (idle_s) begin
      ram_addr_s  = avs.avs_address[ADDR_W-1:0];
      ram_wdata_s = avs.avs_writedata;
    end else begin
      ram_addr_s  = MonAReg;
      ram_wdata_s = wdata_r;
    end
  end

  // Avalon response: RAM reads take one wait state, everything else none.
  always_comb begin
    waitrequest_s = 1'b0;
    readdata_s    = 32'd0;
    if (ram_rd_s) begin
      waitrequest_s = blocked_s || !rd_phase_r;
      if (!blocked_s && rd_phase_r) begin
        readdata_s = ram_q_r;
      end else begin
        readdata_s = 32'd0;
      end
    end else if (ram_wr_s) begin
      waitrequest_s = blocked_s;
    end else if (avs.avs_read) begin
      readdata_s = {29'd0, monitor_go, monitor_error, monitor_ready};
    end else begin
      waitrequest_s = 1'b0;
    end
  end

  assign avs.avs_waitrequest = waitrequest_s;
  assign avs.avs_readdata    = readdata_s;

  // Next-state logic of the debug command FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (a_acc_s) begin
          state_nxt_s = jdo[34] ? ST_RD_ADDR : ST_IDLE;
        end else if (b_acc_s) begin
          state_nxt_s = ST_WR;
        end else if (n_acc_s) begin
          state_nxt_s = ST_RD_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_ADDR: state_nxt_s = ST_RD_CAP;
      ST_RD_CAP:  state_nxt_s = ST_IDLE;
      ST_WR:      state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register; reset abandons any command in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Debug RAM array and its synchronous read register (contents not reset).
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[ram_addr_s] <= ram_wdata_s;
    end
    ram_q_r <= mem_r[ram_addr_s];
  end

  // Debug address/data registers and command-side latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonAReg  <= '0;
      MonDReg  <= 32'd0;
      wdata_r  <= 32'd0;
      rd_inc_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (a_acc_s) begin
            MonAReg <= jdo_addr_s;
          end
          if (b_acc_s) begin
            wdata_r <= jdo[34:3];
          end
          // Only a no-action read walks the address forward afterwards.
          rd_inc_r <= n_acc_s;
        end
        ST_RD_CAP: begin
          MonDReg <= ram_q_r;
          if (rd_inc_r) begin
            MonAReg <= MonAReg + ADDR_W'(1);
          end
        end
        ST_WR: begin
          MonAReg <= MonAReg + ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // CPU RAM read phase: set after the address cycle, cleared on completion or stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_phase_r <= 1'b0;
    end else begin
      rd_phase_r <= ram_rd_s && !blocked_s && !rd_phase_r;
    end
  end

  // Monitor handshake flags; a debug go beats a same-cycle CPU control write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_go    <= 1'b0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else if (go_acc_s) begin
      monitor_go    <= 1'b1;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else if (ctrl_wr_s) begin
      if (avs.avs_writedata[0]) begin
        monitor_ready <= 1'b1;
        monitor_go    <= 1'b0;
      end
      if (avs.avs_writedata[1]) begin
        monitor_error <= 1'b1;
      end
    end
  end

  // Sticky overrun flag for dropped debug commands, cleared by an accepted go.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_overrun <= 1'b0;
    end else if (go_acc_s) begin
      cmd_overrun <= 1'b0;
    end else if (drop_s) begin
      cmd_overrun <= 1'b1;
    end
  end

endmodule
